// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the issue/hazard controller: opcodes,
// instruction field positions, FSM states and the opcode classifier.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W   = 3;
    localparam int OP_W    = 7;
    localparam int CNT_W   = 3;
    localparam int LHS_MSB = 12;
    localparam int LHS_LSB = 10;
    localparam int RHS_MSB = 9;
    localparam int RHS_LSB = 7;
    localparam int OP_MSB  = 6;

    localparam logic [OP_W-1:0] OP_JMP = 7'd2;
    localparam logic [OP_W-1:0] OP_CMP = 7'd3;
    localparam logic [OP_W-1:0] OP_ADD = 7'd96;
    localparam logic [OP_W-1:0] OP_SUB = 7'd97;
    localparam logic [OP_W-1:0] OP_INC = 7'd98;
    localparam logic [OP_W-1:0] OP_DEC = 7'd99;
    localparam logic [OP_W-1:0] OP_SHL = 7'd100;
    localparam logic [OP_W-1:0] OP_SHR = 7'd101;
    localparam logic [OP_W-1:0] OP_AND = 7'd102;
    localparam logic [OP_W-1:0] OP_OR  = 7'd103;
    localparam logic [OP_W-1:0] OP_XOR = 7'd104;
    localparam logic [OP_W-1:0] OP_NOT = 7'd105;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } state_e;

    typedef struct packed {
        logic rd_lhs;
        logic rd_rhs;
        logic wr_lhs;
        logic jump;
    } op_class_t;

    function automatic op_class_t classify(input logic [OP_W-1:0] op);
        op_class_t c;
        c = '0;
        unique case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                c.rd_lhs = 1'b1;
                c.rd_rhs = 1'b1;
                c.wr_lhs = 1'b1;
            end
            OP_INC, OP_DEC, OP_SHL, OP_SHR, OP_NOT: begin
                c.rd_lhs = 1'b1;
                c.wr_lhs = 1'b1;
            end
            OP_CMP: begin
                c.rd_lhs = 1'b1;
                c.rd_rhs = 1'b1;
            end
            OP_JMP: c.jump = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register write-back countdown; a register is busy while its
// counter is nonzero. A fresh load takes priority over the decrement.
module pipe_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int WB_LATENCY = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [REG_W-1:0]    set_idx,
    input  logic [REG_W-1:0]    src0,
    input  logic [REG_W-1:0]    src1,
    input  logic                hold,
    output logic [NUM_REGS-1:0] busy,
    output logic                src0_busy,
    output logic                src1_busy
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(WB_LATENCY);

    logic [CNT_W-1:0] cnt [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (set_en && set_idx == REG_W'(i))
                    cnt[i] <= LOAD;
                else if (!hold && cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_REGS; i++)
            busy[i] = (cnt[i] != '0);
    end

    assign src0_busy = busy[src0];
    assign src1_busy = busy[src1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Issue and hazard control between decode and ALU: RAW stall via the
// scoreboard, plus fetch gating and squash during a jump's shadow.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_REGS      = 8,
    parameter int WB_LATENCY    = 3,
    parameter int BRANCH_SHADOW = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    input  logic [DATA_WIDTH-1:0] dec_instr,
    input  logic                  ex_hold,
    input  logic                  flush,
    output logic                  dec_stall,
    output logic                  issue_valid,
    output logic                  fetch_en,
    output logic [NUM_REGS-1:0]   sb_busy,
    output logic                  state
);

    localparam logic [CNT_W-1:0] SHADOW_LOAD = CNT_W'(BRANCH_SHADOW);

    logic [OP_W-1:0]     opcode;
    logic [REG_W-1:0]    lhs;
    logic [REG_W-1:0]    rhs;
    logic                unused_bits;
    op_class_t           cls;
    state_e              state_q;
    state_e              state_d;
    logic [CNT_W-1:0]    shadow_q;
    logic [CNT_W-1:0]    shadow_d;
    logic                lhs_busy;
    logic                rhs_busy;
    logic                hazard;
    logic                in_run;
    logic                sb_set;
    logic [NUM_REGS-1:0] busy_raw;

    assign opcode      = dec_instr[OP_MSB:0];
    assign lhs         = dec_instr[LHS_MSB:LHS_LSB];
    assign rhs         = dec_instr[RHS_MSB:RHS_LSB];
    assign unused_bits = ^dec_instr[DATA_WIDTH-1:LHS_MSB+1];
    assign cls         = classify(opcode);

    assign in_run = (state_q == ST_RUN);
    assign hazard = dec_valid
                  & ((cls.rd_lhs & lhs_busy)
                  |  (cls.rd_rhs & rhs_busy));

    assign dec_stall   = rst_n & dec_valid & in_run
                       & (hazard | ex_hold);
    assign issue_valid = rst_n & dec_valid & in_run
                       & ~hazard & ~ex_hold & ~flush;
    assign fetch_en    = rst_n & in_run;
    assign sb_busy     = rst_n ? busy_raw : '0;
    assign state       = state_q;
    assign sb_set      = issue_valid & cls.wr_lhs;

    pipe_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .WB_LATENCY (WB_LATENCY)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (sb_set),
        .set_idx   (lhs),
        .src0      (lhs),
        .src1      (rhs),
        .hold      (ex_hold),
        .busy      (busy_raw),
        .src0_busy (lhs_busy),
        .src1_busy (rhs_busy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        if (flush) begin
            state_d  = ST_RUN;
            shadow_d = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (issue_valid && cls.jump) begin
                        state_d  = ST_SHADOW;
                        shadow_d = SHADOW_LOAD;
                    end
                end
                ST_SHADOW: begin
                    // a zero count here can only be stale; leave at once
                    if (!ex_hold) begin
                        if (shadow_q <= 3'd1) begin
                            state_d  = ST_RUN;
                            shadow_d = '0;
                        end else begin
                            shadow_d = shadow_q - 1'b1;
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic
// compared against a timestamp-based model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int WB = 3;
    localparam int BS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid = 1'b0;
    logic [15:0] dec_instr = '0;
    logic        ex_hold = 1'b0;
    logic        flush = 1'b0;
    logic        dec_stall;
    logic        issue_valid;
    logic        fetch_en;
    logic [7:0]  sb_busy;
    logic        state;

    int checks = 0;
    int failures = 0;

    // model: adv counts non-held cycles; a register is busy until adv
    // reaches its ready time, the shadow lasts until adv hits shadow_end
    int adv = 0;
    int ready_at [8];
    int shadow_end = 0;

    logic       e_stall, e_issue, e_fetch, e_state;
    logic [7:0] e_busy;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .ex_hold     (ex_hold),
        .flush       (flush),
        .dec_stall   (dec_stall),
        .issue_valid (issue_valid),
        .fetch_en    (fetch_en),
        .sb_busy     (sb_busy),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic bit is_bin(input int op);
        return op == 96 || op == 97 || op == 102 || op == 103 || op == 104;
    endfunction

    function automatic bit is_un(input int op);
        return op == 98 || op == 99 || op == 100 || op == 101 || op == 105;
    endfunction

    function automatic bit reads_l(input int op);
        return is_bin(op) || is_un(op) || op == 3;
    endfunction

    function automatic bit reads_r(input int op);
        return is_bin(op) || op == 3;
    endfunction

    function automatic bit writes(input int op);
        return is_bin(op) || is_un(op);
    endfunction

    task automatic model_eval();
        int op, l, r;
        bit haz, shd;
        op  = int'(dec_instr[6:0]);
        l   = int'(dec_instr[12:10]);
        r   = int'(dec_instr[9:7]);
        shd = adv < shadow_end;
        haz = dec_valid && ((reads_l(op) && adv < ready_at[l]) ||
                            (reads_r(op) && adv < ready_at[r]));
        for (int i = 0; i < 8; i++)
            e_busy[i] = rst_n && adv < ready_at[i];
        e_state = shd;
        e_fetch = rst_n && !shd;
        e_stall = rst_n && dec_valid && !shd && (haz || ex_hold);
        e_issue = rst_n && dec_valid && !shd && !haz && !ex_hold && !flush;
    endtask

    task automatic tick();
        int op;
        model_eval();
        op = int'(dec_instr[6:0]);
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                ready_at[i] = 0;
            shadow_end = 0;
        end else begin
            if (e_issue && writes(op))
                ready_at[dec_instr[12:10]] = adv + 1 + WB;
            if (flush)
                shadow_end = adv;
            else if (e_issue && op == 2)
                shadow_end = adv + 1 + BS;
            if (!ex_hold)
                adv++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        dec_valid = 1'b0;
        ex_hold   = 1'b0;
        flush     = 1'b0;
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dec_valid = 1'b1;
        dec_instr = 16'h0560;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({fetch_en, dec_stall, issue_valid, sb_busy} !== 11'd0) begin
            failures++;
            $display("FAIL reset_forced got=%b want=0",
                     {fetch_en, dec_stall, issue_valid, sb_busy});
        end
        checks++;
        if (state !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got=%b want=0", state);
        end
        rst_n = 1'b1;
        dec_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_en !== 1'b1 || sb_busy !== 8'h00) begin
            failures++;
            $display("FAIL reset_release fetch=%b busy=%h want 1/00",
                     fetch_en, sb_busy);
        end
        tick();
    endtask

    task automatic test_hazard();
        dec_valid = 1'b1;
        dec_instr = 16'h0560;
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b1) begin
            failures++;
            $display("FAIL haz_c0_issue got=%b want=1", issue_valid);
        end
        tick();
        dec_instr = 16'h0462;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (dec_stall !== 1'b1 || issue_valid !== 1'b0 ||
                sb_busy !== 8'h02) begin
                failures++;
                $display("FAIL haz_c%0d stall=%b issue=%b busy=%h want 1/0/02",
                         c, dec_stall, issue_valid, sb_busy);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (dec_stall !== 1'b0 || issue_valid !== 1'b1 ||
            sb_busy !== 8'h00) begin
            failures++;
            $display("FAIL haz_c4 stall=%b issue=%b busy=%h want 0/1/00",
                     dec_stall, issue_valid, sb_busy);
        end
        tick();
        idle(4);
    endtask

    task automatic test_no_hazard();
        dec_valid = 1'b1;
        dec_instr = 16'h0560;
        tick();
        dec_instr = 16'h0C62;
        @(negedge clk);
        checks++;
        if (dec_stall !== 1'b0 || issue_valid !== 1'b1) begin
            failures++;
            $display("FAIL nohaz stall=%b issue=%b want 0/1",
                     dec_stall, issue_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (sb_busy !== 8'h0A) begin
            failures++;
            $display("FAIL nohaz_busy got=%h want=0a", sb_busy);
        end
        idle(4);
    endtask

    task automatic test_jump();
        dec_valid = 1'b1;
        dec_instr = 16'h0002;
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b1 || fetch_en !== 1'b1) begin
            failures++;
            $display("FAIL jmp_c0 issue=%b fetch=%b want 1/1",
                     issue_valid, fetch_en);
        end
        tick();
        dec_instr = 16'h0560;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if ({fetch_en, issue_valid, dec_stall, state} !== 4'b0001 ||
                sb_busy !== 8'h00) begin
                failures++;
                $display("FAIL jmp_c%0d fis=%b busy=%h want 0001/00", c,
                         {fetch_en, issue_valid, dec_stall, state}, sb_busy);
            end
            tick();
        end
        dec_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_en !== 1'b1 || state !== 1'b0 || sb_busy !== 8'h00) begin
            failures++;
            $display("FAIL jmp_c3 fetch=%b state=%b busy=%h want 1/0/00",
                     fetch_en, state, sb_busy);
        end
        idle(1);
    endtask

    task automatic test_hold();
        dec_valid = 1'b1;
        dec_instr = 16'h0560;
        tick();
        dec_instr = 16'h0462;
        for (int c = 1; c <= 5; c++) begin
            ex_hold = (c == 2);
            @(negedge clk);
            checks++;
            if (issue_valid !== (c == 5) || dec_stall !== (c != 5)) begin
                failures++;
                $display("FAIL hold_c%0d issue=%b stall=%b want %b/%b", c,
                         issue_valid, dec_stall, c == 5, c != 5);
            end
            tick();
        end
        idle(4);
    endtask

    task automatic test_flush_shadow();
        dec_valid = 1'b1;
        dec_instr = 16'h0002;
        tick();
        dec_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 1'b1 || fetch_en !== 1'b0) begin
            failures++;
            $display("FAIL flush_c1 state=%b fetch=%b want 1/0",
                     state, fetch_en);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 1'b0 || fetch_en !== 1'b1) begin
            failures++;
            $display("FAIL flush_c2 state=%b fetch=%b want 0/1",
                     state, fetch_en);
        end
        dec_valid = 1'b1;
        dec_instr = 16'h0002;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        dec_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 1'b0 || fetch_en !== 1'b1) begin
            failures++;
            $display("FAIL flush_jmp state=%b fetch=%b want 0/1",
                     state, fetch_en);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        dec_valid = 1'b1;
        dec_instr = 16'h0560;
        tick();
        dec_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        rst_n = 1'b0;
        dec_valid = 1'b1;
        dec_instr = 16'h0462;
        @(negedge clk);
        checks++;
        if ({fetch_en, dec_stall, issue_valid, sb_busy} !== 11'd0) begin
            failures++;
            $display("FAIL rstmid_forced got=%b want=0",
                     {fetch_en, dec_stall, issue_valid, sb_busy});
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b1 || sb_busy !== 8'h00 || state !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after issue=%b busy=%h state=%b want 1/00/0",
                     issue_valid, sb_busy, state);
        end
        tick();
        dec_instr = 16'h0002;
        tick();
        rst_n = 1'b0;
        dec_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 1'b0 || fetch_en !== 1'b1) begin
            failures++;
            $display("FAIL rst_shadow state=%b fetch=%b want 0/1",
                     state, fetch_en);
        end
        idle(4);
    endtask

    task automatic test_random();
        int ops [13];
        int k;
        ops = '{2, 3, 96, 97, 98, 99, 100, 101, 102, 103, 104, 105, 0};
        for (int n = 0; n < 3000; n++) begin
            k = $urandom_range(0, 12);
            dec_instr[15:13] = 3'($urandom);
            dec_instr[12:10] = 3'($urandom_range(0, 3));
            dec_instr[9:7]   = 3'($urandom_range(0, 3));
            dec_instr[6:0]   = (k == 12) ? 7'($urandom) : 7'(ops[k]);
            dec_valid = ($urandom_range(0, 9) < 8);
            ex_hold   = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            @(negedge clk);
            model_eval();
            checks++;
            if ({dec_stall, issue_valid, fetch_en, state, sb_busy} !==
                {e_stall, e_issue, e_fetch, e_state, e_busy}) begin
                failures++;
                $display("FAIL rand_%0d instr=%h sifs=%b busy=%h want %b/%h",
                         n, dec_instr,
                         {dec_stall, issue_valid, fetch_en, state}, sb_busy,
                         {e_stall, e_issue, e_fetch, e_state}, e_busy);
            end
            tick();
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            ready_at[i] = 0;
        test_reset();
        test_hazard();
        test_no_hazard();
        test_jump();
        test_hold();
        test_flush_shadow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
